// File: rtl/gimli_stream_arbiter.sv
// -----------------------------------------------------------------------------
// gimli_stream_arbiter
//
// Purpose:
//   Shares one Gimli stream core between CHANNELS requesters. A whole operation
//   (one instruction plus all of its din and dout beats) is locked to a single
//   channel. The core's output stream is routed back to the owning channel.
//   The din and dout paths are combinational pass-throughs with no buffering,
//   so backpressure reaches the requester in the same cycle.
//
// Configuration macro:
//   GIMLI_STREAM_ARBITER_PRIORITY_EN
//     - defined:   fixed priority, the lowest requesting index wins.
//     - undefined: round robin, the search starts after the last grant.
//
// Ports:
//   clk, arstn           clock; synchronous active-low reset
//   ch_inst*             per-channel instruction streams (4-bit opcode lanes)
//   ch_din*              per-channel input data streams
//   ch_dout*             per-channel output data streams
//   core_inst*           instruction stream to the core
//   core_din*            input data stream to the core
//   core_dout*           output data stream from the core
//   grant                index of the channel that owns the core
//   busy                 high while a channel holds the lock
// -----------------------------------------------------------------------------
module gimli_stream_arbiter #(
   parameter int          CHANNELS            = 4,
   parameter int          DIN_DOUT_WIDTH      = 32,
   parameter int          DIN_DOUT_SIZE_WIDTH = 2,
   parameter logic [15:0] INST_HAS_DIN        = 16'hFFFF,
   parameter logic [15:0] INST_HAS_DOUT       = 16'hFFFF
) (
   input  logic                                         clk,
   input  logic                                         arstn,
   // requester side
   input  logic [4*CHANNELS-1:0]                        ch_inst,
   input  logic [CHANNELS-1:0]                          ch_inst_valid,
   output logic [CHANNELS-1:0]                          ch_inst_ready,
   input  logic [DIN_DOUT_WIDTH*CHANNELS-1:0]           ch_din,
   input  logic [(DIN_DOUT_SIZE_WIDTH+1)*CHANNELS-1:0]  ch_din_size,
   input  logic [CHANNELS-1:0]                          ch_din_last,
   input  logic [CHANNELS-1:0]                          ch_din_valid,
   output logic [CHANNELS-1:0]                          ch_din_ready,
   output logic [DIN_DOUT_WIDTH*CHANNELS-1:0]           ch_dout,
   output logic [(DIN_DOUT_SIZE_WIDTH+1)*CHANNELS-1:0]  ch_dout_size,
   output logic [CHANNELS-1:0]                          ch_dout_last,
   output logic [CHANNELS-1:0]                          ch_dout_valid,
   input  logic [CHANNELS-1:0]                          ch_dout_ready,
   // core side
   output logic [3:0]                                   core_inst,
   output logic                                         core_inst_valid,
   input  logic                                         core_inst_ready,
   output logic [DIN_DOUT_WIDTH-1:0]                    core_din,
   output logic [DIN_DOUT_SIZE_WIDTH:0]                 core_din_size,
   output logic                                         core_din_last,
   output logic                                         core_din_valid,
   input  logic                                         core_din_ready,
   input  logic [DIN_DOUT_WIDTH-1:0]                    core_dout,
   input  logic [DIN_DOUT_SIZE_WIDTH:0]                 core_dout_size,
   input  logic                                         core_dout_last,
   input  logic                                         core_dout_valid,
   output logic                                         core_dout_ready,
   // status
   output logic [$clog2(CHANNELS)-1:0]                  grant,
   output logic                                         busy
);

   localparam int W  = DIN_DOUT_WIDTH;
   localparam int S  = DIN_DOUT_SIZE_WIDTH + 1;
   localparam int GW = $clog2(CHANNELS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INST = 2'd1,
      S_XFER = 2'd2
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_grant;
   logic            r_din_pending;
   logic            r_dout_pending;
   logic            r_busy;
`ifndef GIMLI_STREAM_ARBITER_PRIORITY_EN
   logic [GW-1:0]   r_last_grant;
`endif

   logic [GW-1:0]   w_winner;
   logic            w_found;
   logic            w_inst_hs;
   logic            w_din_done;
   logic            w_dout_done;
   logic            w_din_pending_nxt;
   logic            w_dout_pending_nxt;

   // -------------------------------------------------------------------------
   // Winner selection
   // -------------------------------------------------------------------------
`ifdef GIMLI_STREAM_ARBITER_PRIORITY_EN
   // Scan downward so the lowest requesting index is the last one written.
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (ch_inst_valid[c]) begin
            w_winner = GW'(c);
            w_found  = 1'b1;
         end
      end
   end
`else
   // Two passes implement the wrap: first the channels above the last grant,
   // then all channels from index 0 upward.
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (!w_found && ch_inst_valid[c] && (c > int'(r_last_grant))) begin
            w_winner = GW'(c);
            w_found  = 1'b1;
         end
      end
      for (int c = 0; c < CHANNELS; c++) begin
         if (!w_found && ch_inst_valid[c]) begin
            w_winner = GW'(c);
            w_found  = 1'b1;
         end
      end
   end
`endif

   // Handshakes are observed on the core-side ports, which are already gated
   // by state, ownership and pending flags.
   assign w_inst_hs          = core_inst_valid & core_inst_ready;
   assign w_din_done         = core_din_valid  & core_din_ready  & core_din_last;
   assign w_dout_done        = core_dout_valid & core_dout_ready & core_dout_last;
   assign w_din_pending_nxt  = r_din_pending  & ~w_din_done;
   assign w_dout_pending_nxt = r_dout_pending & ~w_dout_done;

   // -------------------------------------------------------------------------
   // Operation-lock FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!arstn) begin
         r_state        <= S_IDLE;
         r_grant        <= '0;
         r_din_pending  <= 1'b0;
         r_dout_pending <= 1'b0;
         r_busy         <= 1'b0;
`ifndef GIMLI_STREAM_ARBITER_PRIORITY_EN
         r_last_grant   <= GW'(CHANNELS - 1);
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant      <= w_winner;
`ifndef GIMLI_STREAM_ARBITER_PRIORITY_EN
                  r_last_grant <= w_winner;
`endif
                  r_state      <= S_INST;
                  r_busy       <= 1'b1;
               end
            end
            S_INST: begin
               if (w_inst_hs) begin
                  r_din_pending  <= INST_HAS_DIN[core_inst];
                  r_dout_pending <= INST_HAS_DOUT[core_inst];
                  if (INST_HAS_DIN[core_inst] || INST_HAS_DOUT[core_inst]) begin
                     r_state <= S_XFER;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            S_XFER: begin
               r_din_pending  <= w_din_pending_nxt;
               r_dout_pending <= w_dout_pending_nxt;
               // Both last handshakes in one cycle finish the operation here.
               if (!w_din_pending_nxt && !w_dout_pending_nxt) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Routing. Every output is forced to 0 while arstn is low, so the reset
   // takes effect on the ports immediately rather than one edge later.
   // -------------------------------------------------------------------------
   always_comb begin
      ch_inst_ready   = '0;
      ch_din_ready    = '0;
      ch_dout         = '0;
      ch_dout_size    = '0;
      ch_dout_last    = '0;
      ch_dout_valid   = '0;
      core_inst       = '0;
      core_inst_valid = 1'b0;
      core_din        = '0;
      core_din_size   = '0;
      core_din_last   = 1'b0;
      core_din_valid  = 1'b0;
      core_dout_ready = 1'b0;
      grant           = '0;
      busy            = 1'b0;
      if (arstn) begin
         grant = r_grant;
         busy  = r_busy;
         for (int c = 0; c < CHANNELS; c++) begin
            if (GW'(c) == r_grant) begin
               if (r_state == S_INST) begin
                  core_inst        = ch_inst[4*c +: 4];
                  core_inst_valid  = ch_inst_valid[c];
                  ch_inst_ready[c] = core_inst_ready;
               end
               if ((r_state == S_XFER) && r_din_pending) begin
                  core_din        = ch_din[W*c +: W];
                  core_din_size   = ch_din_size[S*c +: S];
                  core_din_last   = ch_din_last[c];
                  core_din_valid  = ch_din_valid[c];
                  ch_din_ready[c] = core_din_ready;
               end
               if ((r_state == S_XFER) && r_dout_pending) begin
                  ch_dout[W*c +: W]      = core_dout;
                  ch_dout_size[S*c +: S] = core_dout_size;
                  ch_dout_last[c]        = core_dout_last;
                  ch_dout_valid[c]       = core_dout_valid;
                  core_dout_ready        = ch_dout_ready[c];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_gimli_stream_arbiter.sv
module tb_gimli_stream_arbiter;

   localparam int CH = 4;
   localparam int W  = 32;
   localparam int SW = 2;

   logic                 clk = 1'b0;
   logic                 arstn;
   logic [4*CH-1:0]      ch_inst;
   logic [CH-1:0]        ch_inst_valid;
   logic [CH-1:0]        ch_inst_ready;
   logic [W*CH-1:0]      ch_din;
   logic [(SW+1)*CH-1:0] ch_din_size;
   logic [CH-1:0]        ch_din_last;
   logic [CH-1:0]        ch_din_valid;
   logic [CH-1:0]        ch_din_ready;
   logic [W*CH-1:0]      ch_dout;
   logic [(SW+1)*CH-1:0] ch_dout_size;
   logic [CH-1:0]        ch_dout_last;
   logic [CH-1:0]        ch_dout_valid;
   logic [CH-1:0]        ch_dout_ready;
   logic [3:0]           core_inst;
   logic                 core_inst_valid;
   logic                 core_inst_ready;
   logic [W-1:0]         core_din;
   logic [SW:0]          core_din_size;
   logic                 core_din_last;
   logic                 core_din_valid;
   logic                 core_din_ready;
   logic [W-1:0]         core_dout;
   logic [SW:0]          core_dout_size;
   logic                 core_dout_last;
   logic                 core_dout_valid;
   logic                 core_dout_ready;
   logic [1:0]           grant;
   logic                 busy;

   int n_checks = 0;
   int n_errors = 0;

   // Opcode 0 has neither din nor dout; every other opcode has both.
   gimli_stream_arbiter #(
      .CHANNELS(CH), .DIN_DOUT_WIDTH(W), .DIN_DOUT_SIZE_WIDTH(SW),
      .INST_HAS_DIN(16'hFFFE), .INST_HAS_DOUT(16'hFFFE)
   ) dut (
      .clk(clk), .arstn(arstn),
      .ch_inst(ch_inst), .ch_inst_valid(ch_inst_valid), .ch_inst_ready(ch_inst_ready),
      .ch_din(ch_din), .ch_din_size(ch_din_size), .ch_din_last(ch_din_last),
      .ch_din_valid(ch_din_valid), .ch_din_ready(ch_din_ready),
      .ch_dout(ch_dout), .ch_dout_size(ch_dout_size), .ch_dout_last(ch_dout_last),
      .ch_dout_valid(ch_dout_valid), .ch_dout_ready(ch_dout_ready),
      .core_inst(core_inst), .core_inst_valid(core_inst_valid), .core_inst_ready(core_inst_ready),
      .core_din(core_din), .core_din_size(core_din_size), .core_din_last(core_din_last),
      .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
      .core_dout(core_dout), .core_dout_size(core_dout_size), .core_dout_last(core_dout_last),
      .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_data();
      ch_din_valid    = '0;
      ch_din_last     = '0;
      core_din_ready  = 1'b0;
      core_dout_valid = 1'b0;
      core_dout_last  = 1'b0;
      ch_dout_ready   = '0;
   endtask

   task automatic do_reset(input logic [3:0] req_after);
      @(negedge clk);
      arstn = 1'b0;
      ch_inst_valid = '0;
      core_inst_ready = 1'b0;
      clear_data();
      @(negedge clk);
      @(negedge clk);
      arstn = 1'b1;
      ch_inst_valid = req_after;
      #1;
      check("post_rst_inst_valid", core_inst_valid, 1'b0);
      check("post_rst_inst_ready", ch_inst_ready, 4'b0000);
      check("post_rst_busy", busy, 1'b0);
   endtask

   // Entered with the DUT in INST; runs one single-beat din/dout operation whose
   // din_last and dout_last handshakes share a cycle, then sets the next
   // request vector in the IDLE cycle that follows.
   task automatic do_op(input int exp_g, input logic [3:0] next_req, input string tag);
      logic [3:0] oh;
      oh = 4'b0001 << exp_g;
      @(negedge clk);
      core_inst_ready = 1'b1;
      #1;
      check({tag, "_grant"}, grant, exp_g);
      check({tag, "_inst_ready"}, ch_inst_ready, oh);
      @(negedge clk);
      core_inst_ready = 1'b0;
      ch_din_valid    = '1;
      ch_din_last     = '1;
      core_din_ready  = 1'b1;
      core_dout_valid = 1'b1;
      core_dout_last  = 1'b1;
      ch_dout_ready   = '1;
      #1;
      check({tag, "_din_ready"}, ch_din_ready, oh);
      check({tag, "_dout_valid"}, ch_dout_valid, oh);
      @(negedge clk);
      clear_data();
      ch_inst_valid = next_req;
      #1;
      check({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   int exp_t2 [5];
   int exp_t3 [3];

   initial begin
`ifdef GIMLI_STREAM_ARBITER_PRIORITY_EN
      exp_t2 = '{0, 0, 0, 0, 0};
      exp_t3 = '{1, 1, 1};
`else
      exp_t2 = '{0, 1, 2, 3, 0};
      exp_t3 = '{1, 3, 1};
`endif
      arstn           = 1'b0;
      ch_inst         = 16'h5555;
      ch_inst_valid   = '0;
      ch_din          = '0;
      ch_din_size     = '0;
      core_inst_ready = 1'b0;
      core_dout       = '0;
      core_dout_size  = '0;
      clear_data();

      // Outputs are zero while reset is held
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_grant", grant, 2'd0);
      check("rst_dout_valid", ch_dout_valid, 4'b0000);
      do_reset(4'b0000);

      // Single channel: ch2, 3 din beats then 2 dout beats
      @(negedge clk);
      ch_inst_valid = 4'b0100;
      #1;
      check("t1_idle_inst_ready", ch_inst_ready, 4'b0000);
      @(negedge clk);
      #1;
      check("t1_grant", grant, 2'd2);
      check("t1_busy", busy, 1'b1);
      check("t1_core_inst", {core_inst_valid, core_inst}, 5'h15);
      check("t1_inst_ready_lo", ch_inst_ready, 4'b0000);
      core_inst_ready = 1'b1;
      #1;
      check("t1_inst_ready_hi", ch_inst_ready, 4'b0100);
      for (int b = 0; b < 3; b++) begin
         logic [31:0] d;
         d = 32'h1234_0000 + 32'(b);
         @(negedge clk);
         ch_inst_valid   = '0;
         core_inst_ready = 1'b0;
         ch_din          = {32'hDDDD_0003, d, 32'hBBBB_0001, 32'hAAAA_0000};
         ch_din_size     = 12'o7374;
         ch_din_valid    = 4'b1111;
         ch_din_last     = {1'b1, (b == 2), 1'b1, 1'b1};
         core_din_ready  = 1'b1;
         #1;
         check($sformatf("t1_din%0d", b), core_din, d);
         check($sformatf("t1_din_size%0d", b), core_din_size, 3'd3);
         check($sformatf("t1_din_last%0d", b), core_din_last, (b == 2));
         check($sformatf("t1_din_ready%0d", b), ch_din_ready, 4'b0100);
      end
      for (int b = 0; b < 2; b++) begin
         logic [31:0] d;
         d = 32'hC0DE_0000 + 32'(b);
         @(negedge clk);
         clear_data();
         core_dout       = d;
         core_dout_size  = 3'd4;
         core_dout_valid = 1'b1;
         core_dout_last  = (b == 1);
         ch_dout_ready   = 4'b1111;
         #1;
         check($sformatf("t1_din_closed%0d", b), ch_din_ready, 4'b0000);
         check($sformatf("t1_dout%0d", b), ch_dout, {32'h0, d, 64'h0});
         check($sformatf("t1_dout_size%0d", b), ch_dout_size, 12'o0400);
         check($sformatf("t1_dout_valid%0d", b), ch_dout_valid, 4'b0100);
         check($sformatf("t1_dout_last%0d", b), ch_dout_last, {1'b0, (b == 1), 2'b00});
         check($sformatf("t1_core_dout_ready%0d", b), core_dout_ready, 1'b1);
         check($sformatf("t1_busy_xfer%0d", b), busy, 1'b1);
      end
      @(negedge clk);
      #1;
      check("t1_idle_after", busy, 1'b0);
      check("t1_idle_dout_ready", core_dout_ready, 1'b0);
      clear_data();

      // All channels requesting continuously, then ch1 and ch3 only
      do_reset(4'b1111);
      for (int i = 0; i < 5; i++)
         do_op(exp_t2[i], (i == 4) ? 4'b1010 : 4'b1111, $sformatf("t2_op%0d", i));
      for (int i = 0; i < 3; i++)
         do_op(exp_t3[i], (i == 2) ? 4'b0000 : 4'b1010, $sformatf("t3_op%0d", i));

      // Opcode 0: no din, no dout; busy high for exactly one cycle
      @(negedge clk);
      ch_inst         = 16'h5550;
      ch_inst_valid   = 4'b0001;
      core_inst_ready = 1'b1;
      #1;
      check("t4_busy_pre", busy, 1'b0);
      @(negedge clk);
      #1;
      check("t4_busy_inst", busy, 1'b1);
      check("t4_grant", grant, 2'd0);
      check("t4_inst_ready", ch_inst_ready, 4'b0001);
      @(negedge clk);
      ch_inst_valid = '0;
      #1;
      check("t4_busy_post", busy, 1'b0);
      check("t4_inst_valid_post", core_inst_valid, 1'b0);
      ch_inst = 16'h5555;

      // Reset in the middle of a dout stream on ch3
      @(negedge clk);
      ch_inst_valid = 4'b1000;
      @(negedge clk);
      #1;
      check("t6_grant", grant, 2'd3);
      @(negedge clk);
      ch_inst_valid   = '0;
      core_inst_ready = 1'b0;
      ch_din_valid    = 4'b1000;
      ch_din_last     = 4'b1000;
      core_din_ready  = 1'b1;
      @(negedge clk);
      clear_data();
      core_dout       = 32'hFEED_F00D;
      core_dout_valid = 1'b1;
      ch_dout_ready   = 4'b1111;
      #1;
      check("t6_dout_valid", ch_dout_valid, 4'b1000);
      check("t6_dout_ready", core_dout_ready, 1'b1);
      @(negedge clk);
      arstn = 1'b0;
      #1;
      check("t6_rst_dout_valid", ch_dout_valid, 4'b0000);
      check("t6_rst_dout_ready", core_dout_ready, 1'b0);
      check("t6_rst_dout", ch_dout, 128'h0);
      check("t6_rst_busy", busy, 1'b0);
      @(negedge clk);
      arstn = 1'b1;
      ch_inst_valid = 4'b1111;
      #1;
      check("t6_post_dout_valid", ch_dout_valid, 4'b0000);
      check("t6_post_dout_ready", core_dout_ready, 1'b0);
      check("t6_post_inst_valid", core_inst_valid, 1'b0);
      check("t6_post_busy", busy, 1'b0);
      @(negedge clk);
      #1;
      check("t6_next_grant", grant, 2'd0);
      check("t6_next_inst_valid", core_inst_valid, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
